// File: rtl/readout_sequencer_pkg.sv
// Shared definitions for the readout sequencer: the FSM state encoding and
// the default frame header byte and word limit.
package readout_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_FETCH,
    ST_WAIT,
    ST_SEND,
    ST_TRAILER,
    ST_FINISH
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
  localparam logic [15:0] MAX_WORDS_DEF = 16'hFFFF;

endpackage

// File: rtl/readout_sequencer_byte_tx_slot.sv
// Single-byte output holding register with a valid/ready handshake. A new byte
// may only be loaded when the slot is empty or its current byte is being taken.
module byte_tx_slot (
  input  logic       i_clk,
  input  logic       _mrst,
  input  logic       i_load,
  input  logic [7:0] i_load_byte,
  input  logic       i_ready,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_xfer
);

  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;

  assign o_xfer = valid_q & i_ready;

  always_comb begin
    byte_d  = byte_q;
    valid_d = valid_q;
    if (i_load) begin
      byte_d  = i_load_byte;
      valid_d = 1'b1;
    end else if (o_xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!_mrst) begin
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      byte_q  <= byte_d;
      valid_q <= valid_d;
    end
  end

  assign o_byte  = byte_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/readout_sequencer.sv
// Drains the capture FIFO into a byte stream framed as
// SYNC, {word bytes MSB first}*, count[15:8], count[7:0].
//
// state   | meaning
// IDLE    | waiting for i_start
// HEADER  | SYNC_BYTE presented
// FETCH   | decide: read next word or close the frame
// WAIT    | FIFO data arriving, latch it
// SEND    | four word bytes presented, MSB first
// TRAILER | word count presented, high byte first
// FINISH  | one-cycle o_done
module readout_sequencer
  import readout_sequencer_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [15:0] MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        i_clk,
  input  logic        _mrst,
  input  logic        i_start,
  input  logic        i_fifo_empty,
  output logic        o_fifo_rdreq,
  input  logic [31:0] i_fifo_q,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  input  logic        i_byte_ready,
  output logic        o_busy,
  output logic [15:0] o_word_count,
  output logic        o_done
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic [1:0]  idx_q, idx_d;
  logic        load;
  logic [7:0]  load_byte;
  logic        xfer;
  logic        rdreq;

  byte_tx_slot u_slot (
    .i_clk       (i_clk),
    ._mrst       (_mrst),
    .i_load      (load),
    .i_load_byte (load_byte),
    .i_ready     (i_byte_ready),
    .o_byte      (o_byte),
    .o_valid     (o_byte_valid),
    .o_xfer      (xfer)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    load      = 1'b0;
    load_byte = 8'h00;
    rdreq     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d   = ST_HEADER;
          cnt_d     = 16'h0000;
          load      = 1'b1;
          load_byte = SYNC_BYTE;
        end
      end
      ST_HEADER: begin
        if (xfer) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (i_fifo_empty || (cnt_q == MAX_WORDS)) begin
          state_d   = ST_TRAILER;
          idx_d     = 2'd0;
          load      = 1'b1;
          load_byte = cnt_q[15:8];
        end else begin
          rdreq   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        shreg_d   = i_fifo_q;
        cnt_d     = cnt_q + 16'd1;
        idx_d     = 2'd0;
        load      = 1'b1;
        load_byte = i_fifo_q[31:24];
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          if (idx_q == 2'd3) begin
            state_d = ST_FETCH;
          end else begin
            // rotate so the next byte always sits at [31:24] after the move
            idx_d     = idx_q + 2'd1;
            shreg_d   = {shreg_q[23:0], shreg_q[31:24]};
            load      = 1'b1;
            load_byte = shreg_q[23:16];
          end
        end
      end
      ST_TRAILER: begin
        if (xfer) begin
          if (idx_q == 2'd0) begin
            idx_d     = 2'd1;
            load      = 1'b1;
            load_byte = cnt_q[7:0];
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!_mrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'h0000;
      shreg_q <= 32'h0000_0000;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign o_fifo_rdreq = rdreq;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_FINISH);
  assign o_word_count = cnt_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Randomized bench for readout_sequencer: a queue-based FIFO and frame model
// predict every byte stream, read count and frame timing.
module tb_readout_sequencer;

  localparam int MAXW = 3;

  logic        clk = 1'b0;
  logic        mrst, start, empty, rdreq, valid, ready, busy, done;
  logic [31:0] fifo_q;
  logic [7:0]  obyte;
  logic [15:0] wcnt;

  always #5 clk = ~clk;

  readout_sequencer #(.SYNC_BYTE(8'hA5), .MAX_WORDS(16'(MAXW))) dut (
    .i_clk        (clk),
    ._mrst        (mrst),
    .i_start      (start),
    .i_fifo_empty (empty),
    .o_fifo_rdreq (rdreq),
    .i_fifo_q     (fifo_q),
    .o_byte       (obyte),
    .o_byte_valid (valid),
    .i_byte_ready (ready),
    .o_busy       (busy),
    .o_word_count (wcnt),
    .o_done       (done)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fifo[$];
  logic [7:0]  got[$];
  logic [7:0]  expb[$];
  int          rd_cnt, done_cnt, ready_mode;
  bit          done_now;
  bit          prev_stall;
  logic [7:0]  prev_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // per-cycle protocol observer and transfer logger
  initial begin
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (mrst !== 1'b1) begin
        prev_stall = 1'b0;
      end else begin
        chk("rdreq_while_empty", 32'(rdreq & empty), 32'd0);
        if (!busy) begin
          chk("idle_valid", 32'(valid), 32'd0);
          chk("idle_rdreq", 32'(rdreq), 32'd0);
        end
        if (done) chk("done_valid", 32'(valid), 32'd0);
        if (prev_stall) begin
          chk("stall_valid", 32'(valid), 32'd1);
          chk("stall_byte", 32'(obyte), 32'(prev_byte));
        end
        if (valid && ready) got.push_back(obyte);
        if (rdreq) rd_cnt++;
        if (done) done_cnt++;
        prev_stall = valid && !ready;
        prev_byte  = obyte;
      end
    end
  end

  // one clock: sample at negedge, update FIFO/ready model just after posedge
  task automatic cyc();
    bit rd;
    @(negedge clk);
    rd       = (rdreq === 1'b1) && (mrst === 1'b1);
    done_now = (done === 1'b1) && (mrst === 1'b1);
    @(posedge clk);
    #1;
    if (rd && fifo.size() > 0) fifo_q = fifo.pop_front();
    empty = (fifo.size() == 0);
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic load_words(input logic [31:0] w[$]);
    fifo.delete();
    foreach (w[i]) fifo.push_back(w[i]);
    empty = (fifo.size() == 0);
  endtask

  task automatic run_frame(input int mode, input bit timing, input bit inject, input string tag);
    int n, remain, k;
    bit ok;
    n = (fifo.size() < MAXW) ? fifo.size() : MAXW;
    remain = fifo.size() - n;
    expb.delete();
    expb.push_back(8'hA5);
    for (int i = 0; i < n; i++) begin
      for (int b = 3; b >= 0; b--) expb.push_back(8'(fifo[i] >> (8 * b)));
    end
    expb.push_back(8'(n >> 8));
    expb.push_back(8'(n));
    got.delete();
    rd_cnt = 0;
    done_cnt = 0;
    ready_mode = mode;
    if (mode == 0) ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    k = 0;
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      cyc();
      k++;
      if (done_now) begin
        ok = 1'b1;
        break;
      end
      start = (inject && $urandom_range(0, 5) == 0);
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    if (timing) chk({tag, "_done_cycle"}, 32'(k), 32'(6 * n + 5));
    repeat (3) cyc();
    chk({tag, "_word_count"}, 32'(wcnt), 32'(n));
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_rd_pulses"}, 32'(rd_cnt), 32'(n));
    chk({tag, "_fifo_remain"}, 32'(fifo.size()), 32'(remain));
    chk({tag, "_byte_count"}, 32'(got.size()), 32'(expb.size()));
    for (int i = 0; i < expb.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(expb[i]));
  endtask

  task automatic check_lit(input string tag, input logic [7:0] lit[$]);
    chk({tag, "_lit_len"}, 32'(got.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size() && i < got.size(); i++)
      chk($sformatf("%s_lit%0d", tag, i), 32'(got[i]), 32'(lit[i]));
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  lit[$];
    bit          seen;
    mrst = 1'b0;
    start = 1'b0;
    empty = 1'b1;
    fifo_q = 32'h0;
    ready = 1'b1;
    ready_mode = 0;
    rd_cnt = 0;
    done_cnt = 0;
    repeat (3) cyc();
    chk("rst_byte", 32'(obyte), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdreq", 32'(rdreq), 32'd0);
    chk("rst_wcnt", 32'(wcnt), 32'd0);

    // single word; start sampled on the very first edge out of reset
    w = '{32'h11223344};
    load_words(w);
    mrst = 1'b1;
    run_frame(0, 1'b1, 1'b0, "one_word");
    lit = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h01};
    check_lit("one_word", lit);

    w.delete();
    load_words(w);
    run_frame(0, 1'b1, 1'b0, "empty");
    lit = '{8'hA5, 8'h00, 8'h00};
    check_lit("empty", lit);

    w = '{32'hDEADBEEF, 32'h0BADF00D};
    load_words(w);
    run_frame(1, 1'b0, 1'b0, "toggle");
    lit = '{8'hA5, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D, 8'h00, 8'h02};
    check_lit("toggle", lit);

    w = '{32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004, 32'h50000005};
    load_words(w);
    run_frame(0, 1'b1, 1'b0, "limit");
    chk("limit_trl_hi", 32'(got[got.size() - 2]), 32'h00);
    chk("limit_trl_lo", 32'(got[got.size() - 1]), 32'h03);

    // reset while the second word byte is on the output
    w = '{32'h01020304, 32'hA1B2C3D4, 32'h55667788};
    load_words(w);
    ready_mode = 0;
    ready = 1'b1;
    got.delete();
    rd_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (got.size() == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_reached", 32'(seen), 32'd1);
    mrst = 1'b0;
    cyc();
    chk("rst_mid_byte", 32'(obyte), 32'd0);
    chk("rst_mid_valid", 32'(valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_rdreq", 32'(rdreq), 32'd0);
    chk("rst_mid_wcnt", 32'(wcnt), 32'd0);
    mrst = 1'b1;
    repeat (4) cyc();
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    chk("rst_mid_no_reads", 32'(rd_cnt), 32'd1);
    run_frame(0, 1'b1, 1'b0, "after_rst");
    lit = '{8'hA5, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h02};
    check_lit("after_rst", lit);

    w = '{32'hCAFE0001, 32'hCAFE0002};
    load_words(w);
    run_frame(0, 1'b1, 1'b1, "restart_ign");

    for (int f = 0; f < 25; f++) begin
      int nw, mode;
      nw = $urandom_range(0, 5);
      for (int i = 0; i < nw; i++) fifo.push_back($urandom);
      empty = (fifo.size() == 0);
      mode = $urandom_range(0, 2);
      run_frame(mode, mode == 0, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, header byte sent at start of each dump frame.
REQ-002 Parameter MAX_WORDS, default 16'hFFFF, maximum words drained per frame.
REQ-003 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 _mrst  input  1  synchronous, active-low reset.
REQ-005 i_start  input  1  single-cycle request to begin a dump frame.
REQ-006 i_fifo_empty  input  1  capture FIFO empty flag.
REQ-007 o_fifo_rdreq  output  1  FIFO read request; data valid on i_fifo_q one cycle later.
REQ-008 i_fifo_q  input  32  FIFO read data.
REQ-009 o_byte  output  8  outbound byte.
REQ-010 o_byte_valid  output  1  o_byte holds a valid byte.
REQ-011 i_byte_ready  input  1  sink accepts the byte; a transfer occurs when valid and ready are both high.
REQ-012 o_busy  output  1  frame in progress.
REQ-013 o_word_count  output  16  words drained in the current or last frame.
REQ-014 o_done  output  1  single-cycle pulse at end of frame.

Function
REQ-015 States SHALL be IDLE, HEADER, FETCH, WAIT, SEND, TRAILER, FINISH.
REQ-016 IDLE: i_start=1 -> HEADER; clear o_word_count; o_busy=1 from the next cycle.
REQ-017 i_start SHALL be ignored outside IDLE.
REQ-018 HEADER: present SYNC_BYTE; on transfer -> FETCH.
REQ-019 FETCH: if i_fifo_empty=1 or o_word_count==MAX_WORDS -> TRAILER; otherwise assert o_fifo_rdreq for exactly one cycle -> WAIT.
REQ-020 o_fifo_rdreq SHALL never be asserted while i_fifo_empty=1 or outside FETCH.
REQ-021 WAIT: latch i_fifo_q into a 32-bit shift register; increment o_word_count; -> SEND.
REQ-022 SEND: present the 4 latched bytes MSB first (bits 31:24 first), one per transfer; after the 4th transfer -> FETCH.
REQ-023 TRAILER: present o_word_count[15:8], then o_word_count[7:0]; after the 2nd transfer -> FINISH.
REQ-024 FINISH: o_done=1 for one cycle; o_busy=0 from the next cycle; -> IDLE.
REQ-025 o_byte and o_byte_valid SHALL stay stable while o_byte_valid=1 and i_byte_ready=0; o_byte_valid=0 in IDLE, FETCH, WAIT and FINISH.
REQ-026 With i_byte_ready held high, each byte SHALL occupy exactly one cycle; per-word cost = 6 cycles (FETCH, WAIT, 4×SEND).
REQ-027 The word count SHALL never wrap; the MAX_WORDS limit ends the frame.
REQ-028 An empty FIFO at the first FETCH SHALL yield frame A5 00 00.
REQ-029 i_fifo_empty rising during SEND SHALL not abort the word in progress.

Reset
REQ-030 _mrst=0 at a clock edge SHALL force IDLE, o_fifo_rdreq=0, o_byte=0, o_byte_valid=0, o_busy=0, o_done=0, o_word_count=0, and a zero shift register.
REQ-031 Reset mid-frame SHALL abandon the frame without o_done and without further FIFO reads.
REQ-032 The first i_start accepted is the one sampled on the first edge with _mrst=1.

Structure
REQ-033 A shared package SHALL hold the state encoding and the SYNC_BYTE and MAX_WORDS defaults.
REQ-034 One sub-module, byte_tx_slot, SHALL hold the o_byte/o_byte_valid register with load and handshake logic; the FSM SHALL live in readout_sequencer.

Verification
REQ-035 FIFO holds 32'h11223344, ready=1, pulse start -> bytes A5 11 22 33 44 00 01, then o_done, o_word_count=1.
REQ-036 Empty FIFO, start -> bytes A5 00 00; o_fifo_rdreq never high.
REQ-037 FIFO holds 2 words, ready toggled 1/0 every cycle -> byte sequence identical to the ready=1 case; o_byte stable while stalled.
REQ-038 MAX_WORDS=3, FIFO holds 5 words -> exactly 3 rdreq pulses; trailer 00 03; 2 words remain.
REQ-039 _mrst=0 during the 2nd SEND byte -> all outputs 0 next cycle; no o_done; a new start produces a clean frame from the next word.
REQ-040 start pulsed again mid-frame -> ignored; exactly one o_done.
